mem_ctrl_icache: RTL

MEM_CTRL_ICACHE -- requirements
Module: mem_ctrl_icache

---
 rtl/mem_ctrl_icache.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl_icache.sv
// mem_ctrl_icache: byte-wide memory controller arbitrating instruction fetch
// and load/store traffic, with a direct-mapped one-word-per-line I-cache.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   rdy                 global enable (0 = freeze all state, no writes)
//   rob_clear           pipeline flush; aborts in-flight fetch/load
//   mem_din/mem_dout    byte read (one cycle after mem_a) / byte write data
//   mem_a, mem_wr       byte address and write strobe (combinational)
//   io_buffer_full      UART back-pressure for stores to 0x3xxxx
//   if_*                fetch request / registered one-cycle response
//   ls_*                load/store request, accept strobe, registered response
module mem_ctrl_icache #(
  parameter int ICACHE_IDX_W = 4,
  parameter int MEM_ADDR_W   = 18   // >= 18: bits [17:16] select the UART window
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rob_clear,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_valid,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_instr_addr,
  input  logic        ls_valid,
  input  logic        ls_is_store,
  input  logic [2:0]  ls_op,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_accept,
  output logic        ls_ready,
  output logic [31:0] ls_rdata
);

  localparam int LINES = 1 << ICACHE_IDX_W;
  localparam int TAG_W = MEM_ADDR_W - ICACHE_IDX_W - 2;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_STORE} state_e;

  state_e                          state_q, state_d;
  logic [MEM_ADDR_W-1:0]           addr_q, addr_d;
  logic [31:0]                     pc_q, pc_d;
  logic [2:0]                      op_q, op_d;
  logic [31:0]                     wdata_q, wdata_d;
  logic [2:0]                      cnt_q, cnt_d;
  logic [31:0]                     buf_q, buf_d;
  logic                            if_ready_q, if_ready_d;
  logic [31:0]                     if_instr_q, if_instr_d;
  logic [31:0]                     if_instr_addr_q, if_instr_addr_d;
  logic                            ls_ready_q, ls_ready_d;
  logic [31:0]                     ls_rdata_q, ls_rdata_d;
  logic [LINES-1:0]                valid_q, valid_d;
  logic [LINES-1:0][TAG_W-1:0]     tag_q, tag_d;
  logic [LINES-1:0][31:0]          data_q, data_d;

  logic [31:0] mem_a_c;
  logic [7:0]  mem_dout_c;
  logic        mem_wr_c;
  logic        ls_accept_c;

  // Byte count of an access; the reserved size encoding 3 behaves as a word.
  function automatic logic [2:0] nbytes(input logic [2:0] op);
    case (op[1:0])
      2'd0:    nbytes = 3'd1;
      2'd1:    nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] ld_ext(input logic [2:0] op, input logic [31:0] w);
    case (op[1:0])
      2'd0:    ld_ext = {{24{w[7]  & ~op[2]}}, w[7:0]};
      2'd1:    ld_ext = {{16{w[15] & ~op[2]}}, w[15:0]};
      default: ld_ext = w;
    endcase
  endfunction

  logic [ICACHE_IDX_W-1:0] f_idx, s_idx, q_idx;
  logic [TAG_W-1:0]        f_tag, s_tag, q_tag;
  logic                    f_hit;
  logic [2:0]              n_q;
  logic [MEM_ADDR_W-1:0]   cur_a;
  logic [1:0]              cap_lane;
  logic                    uart_hold;
  logic                    unused_ok;

  assign f_idx     = if_addr[ICACHE_IDX_W+1:2];
  assign f_tag     = if_addr[MEM_ADDR_W-1:ICACHE_IDX_W+2];
  assign s_idx     = ls_addr[ICACHE_IDX_W+1:2];
  assign s_tag     = ls_addr[MEM_ADDR_W-1:ICACHE_IDX_W+2];
  assign q_idx     = addr_q[ICACHE_IDX_W+1:2];
  assign q_tag     = addr_q[MEM_ADDR_W-1:ICACHE_IDX_W+2];
  assign f_hit     = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign n_q       = nbytes(op_q);
  assign cur_a     = addr_q + MEM_ADDR_W'(cnt_q);   // wraps modulo 2^MEM_ADDR_W
  // cnt_q runs one ahead of the byte arriving on mem_din (1-cycle read latency)
  assign cap_lane  = cnt_q[1:0] - 2'd1;
  assign uart_hold = (addr_q[17:16] == 2'b11) && io_buffer_full;
  assign unused_ok = ^ls_addr[31:MEM_ADDR_W];

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    pc_d            = pc_q;
    op_d            = op_q;
    wdata_d         = wdata_q;
    cnt_d           = cnt_q;
    buf_d           = buf_q;
    if_instr_d      = if_instr_q;
    if_instr_addr_d = if_instr_addr_q;
    ls_rdata_d      = ls_rdata_q;
    valid_d         = valid_q;
    tag_d           = tag_q;
    data_d          = data_q;
    // ready flags are pulses, but like everything else they freeze while rdy=0
    if_ready_d      = rdy ? 1'b0 : if_ready_q;
    ls_ready_d      = rdy ? 1'b0 : ls_ready_q;
    mem_a_c         = '0;
    mem_dout_c      = '0;
    mem_wr_c        = 1'b0;
    ls_accept_c     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // byte 0 of a miss/load goes out in the accept cycle itself
        if (ls_valid)      mem_a_c = 32'(ls_addr[MEM_ADDR_W-1:0]);
        else if (if_valid) mem_a_c = 32'(if_addr[MEM_ADDR_W-1:0]);
        if (rdy) begin
          if (ls_valid) begin
            ls_accept_c = 1'b1;
            addr_d      = ls_addr[MEM_ADDR_W-1:0];
            op_d        = ls_op;
            wdata_d     = ls_wdata;
            buf_d       = '0;
            if (ls_is_store) begin
              state_d = S_STORE;
              cnt_d   = 3'd0;
              // keep the I-cache coherent with self-modifying code
              if (valid_q[s_idx] && (tag_q[s_idx] == s_tag)) valid_d[s_idx] = 1'b0;
            end else begin
              state_d = S_LOAD;
              cnt_d   = 3'd1;
            end
          end else if (if_valid) begin
            if (f_hit) begin
              if_ready_d      = 1'b1;
              if_instr_d      = data_q[f_idx];
              if_instr_addr_d = if_addr;
            end else begin
              state_d = S_FETCH;
              addr_d  = if_addr[MEM_ADDR_W-1:0];
              pc_d    = if_addr;
              cnt_d   = 3'd1;
              buf_d   = '0;
            end
          end
        end
      end

      S_FETCH: begin
        if (cnt_q < 3'd4) mem_a_c = 32'(cur_a);
        if (rdy) begin
          if (rob_clear) begin
            state_d = S_IDLE;
          end else begin
            buf_d[{cap_lane, 3'b000} +: 8] = mem_din;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd4) begin
              valid_d[q_idx]  = 1'b1;
              tag_d[q_idx]    = q_tag;
              data_d[q_idx]   = buf_d;
              if_ready_d      = 1'b1;
              if_instr_d      = buf_d;
              if_instr_addr_d = pc_q;
              state_d         = S_IDLE;
            end
          end
        end
      end

      S_LOAD: begin
        if (cnt_q < n_q) mem_a_c = 32'(cur_a);
        if (rdy) begin
          if (rob_clear) begin
            state_d = S_IDLE;
          end else begin
            buf_d[{cap_lane, 3'b000} +: 8] = mem_din;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == n_q) begin
              ls_ready_d = 1'b1;
              ls_rdata_d = ld_ext(op_q, buf_d);
              state_d    = S_IDLE;
            end
          end
        end
      end

      S_STORE: begin
        // flush never aborts a store: bytes may already be in memory/UART
        mem_a_c    = 32'(cur_a);
        mem_dout_c = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        if (rdy && !uart_hold) begin
          mem_wr_c = 1'b1;
          cnt_d    = cnt_q + 3'd1;
          if (cnt_q == n_q - 3'd1) begin
            ls_ready_d = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      pc_q            <= '0;
      op_q            <= '0;
      wdata_q         <= '0;
      cnt_q           <= '0;
      buf_q           <= '0;
      if_ready_q      <= 1'b0;
      if_instr_q      <= '0;
      if_instr_addr_q <= '0;
      ls_ready_q      <= 1'b0;
      ls_rdata_q      <= '0;
      valid_q         <= '0;
      tag_q           <= '0;
      data_q          <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      pc_q            <= pc_d;
      op_q            <= op_d;
      wdata_q         <= wdata_d;
      cnt_q           <= cnt_d;
      buf_q           <= buf_d;
      if_ready_q      <= if_ready_d;
      if_instr_q      <= if_instr_d;
      if_instr_addr_q <= if_instr_addr_d;
      ls_ready_q      <= ls_ready_d;
      ls_rdata_q      <= ls_rdata_d;
      valid_q         <= valid_d;
      tag_q           <= tag_d;
      data_q          <= data_d;
    end
  end

  // combinational bus outputs are forced quiet while reset is asserted
  assign mem_a         = rst ? 32'd0 : mem_a_c;
  assign mem_dout      = rst ? 8'd0  : mem_dout_c;
  assign mem_wr        = mem_wr_c & ~rst;
  assign ls_accept     = ls_accept_c & ~rst;
  assign if_ready      = if_ready_q;
  assign if_instr      = if_instr_q;
  assign if_instr_addr = if_instr_addr_q;
  assign ls_ready      = ls_ready_q;
  assign ls_rdata      = ls_rdata_q;

endmodule
